// File: rtl/bridge_timer_pkg.sv
// Shared constants for bridge_timer: register word indices, CTRL layout, modes, FSM states.
// TIMER_PRESCALER_EN (optional) enables the PSC register at word index 3.
package bridge_timer_pkg;

    localparam logic [1:0] TIMER_CTRL   = 2'd0;
    localparam logic [1:0] TIMER_PRESET = 2'd1;
    localparam logic [1:0] TIMER_COUNT  = 2'd2;
    localparam logic [1:0] TIMER_PSC    = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_MODE_LSB = 1;
    localparam int CTRL_MODE_MSB = 2;
    localparam int CTRL_IM_BIT   = 3;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    // HWInt vector bit this timer drives
    localparam int TIMER_HWINT_BIT = 2;

    localparam int PSC_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_e;

    typedef struct packed {
        logic       im;
        logic [1:0] mode;
        logic       en;
    } ctrl_t;

endpackage

// File: rtl/bridge_timer_prescaler.sv
// timer_prescaler: divides clk by psc+1 while run is high; only built with TIMER_PRESCALER_EN.
// tick is high in the cycle the count reaches psc.
`ifdef TIMER_PRESCALER_EN
module timer_prescaler
    import bridge_timer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             run,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PSC_W-1:0] cnt_q, cnt_d;

    // >= keeps the divider sane if psc is lowered below the running count
    assign tick = run && (cnt_q >= psc);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = tick ? '0 : cnt_q + PSC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`endif

// File: rtl/bridge_timer.sv
// bridge_timer: bus-mapped countdown timer (one-shot / auto-reload) driving one HWInt bit.
// Define TIMER_PRESCALER_EN to add the PSC register and timer_prescaler.
//   state | meaning
//   IDLE  | stopped, COUNT held
//   LOAD  | COUNT <= PRESET
//   CNT   | counting down
//   INT   | terminal count reached, pending set
module bridge_timer
    import bridge_timer_pkg::*;
#(
    parameter int            DW         = 32,
    parameter logic [DW-1:0] PRESET_RST = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    addr,
    input  logic          we,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          irq
);

    localparam logic [DW-1:0] ONE = DW'(1);

    state_e        state_q, state_d;
    ctrl_t         ctrl_q, ctrl_d;
    logic [DW-1:0] preset_q, preset_d;
    logic [DW-1:0] count_q, count_d;
    logic          pending_q, pending_d;
    logic          ctrl_wr;
    logic          tick;

    assign ctrl_wr = we && (addr == TIMER_CTRL);

`ifdef TIMER_PRESCALER_EN
    logic [PSC_W-1:0] psc_q, psc_d;

    assign psc_d = (we && addr == TIMER_PSC) ? din[PSC_W-1:0] : psc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            psc_q <= '0;
        end else begin
            psc_q <= psc_d;
        end
    end

    timer_prescaler u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  ((state_q == ST_LOAD) || ctrl_wr),
        .run  (state_q == ST_CNT),
        .psc  (psc_q),
        .tick (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        preset_d  = preset_q;
        count_d   = count_q;
        pending_d = pending_q;

        case (state_q)
            ST_IDLE: begin
                if (ctrl_q.en) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_q.en) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    if (count_q > ONE) begin
                        count_d = count_q - ONE;
                    end else begin
                        count_d   = '0;
                        pending_d = 1'b1;
                        state_d   = ST_INT;
                    end
                end
            end
            ST_INT: begin
                if (ctrl_q.mode == MODE_RELOAD) begin
                    pending_d = 1'b0;
                    state_d   = ST_LOAD;
                end else begin
                    ctrl_d.en = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (we && addr == TIMER_PRESET) preset_d = din;

        // A bus write to CTRL overrides whatever the FSM did to EN/pending this cycle
        if (ctrl_wr) begin
            ctrl_d.en   = din[CTRL_EN_BIT];
            ctrl_d.mode = din[CTRL_MODE_MSB:CTRL_MODE_LSB];
            ctrl_d.im   = din[CTRL_IM_BIT];
            pending_d   = 1'b0;
            if (!din[CTRL_EN_BIT]) begin
                state_d = ST_IDLE;
                count_d = count_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            preset_q  <= PRESET_RST;
            count_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            preset_q  <= preset_d;
            count_q   <= count_d;
            pending_q <= pending_d;
        end
    end

    always_comb begin
        dout = '0;
        case (addr)
            TIMER_CTRL:   dout = {{(DW-4){1'b0}}, ctrl_q};
            TIMER_PRESET: dout = preset_q;
            TIMER_COUNT:  dout = count_q;
            TIMER_PSC: begin
`ifdef TIMER_PRESCALER_EN
                dout = {{(DW-PSC_W){1'b0}}, psc_q};
`else
                dout = '0;
`endif
            end
            default: dout = '0;
        endcase
    end

    assign irq = pending_q & ctrl_q.im;

endmodule

// File: tb/tb_bridge_timer.sv
// Scoreboard bench for bridge_timer: stimulus pushes per-cycle expectations from an
// arithmetic timeline model; a negedge monitor pops and compares dout/irq.
`timescale 1ns/1ps
module tb_bridge_timer;
    import bridge_timer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        we  = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [31:0] din = 32'd0;
    logic [31:0] dout;
    logic        irq;

    bridge_timer #(.DW(32), .PRESET_RST(32'h0)) dut (
        .clk(clk), .rst(rst), .addr(addr), .we(we), .din(din), .dout(dout), .irq(irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [1:0]  a;
        logic [31:0] d;
        logic        irq;
    } exp_t;
    exp_t sbq[$];

    // Timeline model: a run started by a CTRL write at edge m_k
    logic [31:0] m_preset = 32'd0;
    logic [31:0] m_n      = 32'd0;
    logic [31:0] m_hold   = 32'd0;
    int          m_k      = 0;
    logic        m_run    = 1'b0;
    logic [1:0]  m_mode   = 2'd0;
    logic        m_im     = 1'b0;
    logic [15:0] m_psc    = 16'd0;

    function automatic int m_q();
        return int'(m_psc) + 1;
    endfunction

    function automatic int m_span();
        return ((m_n == 32'd0) ? 1 : int'(m_n)) * m_q();
    endfunction

    function automatic logic [31:0] sat(input logic [31:0] n, input int s);
        return (n > 32'(s)) ? n - 32'(s) : 32'd0;
    endfunction

    function automatic logic [31:0] m_count(input int t);
        int dt, ph, per;
        if (!m_run) return m_hold;
        dt = t - m_k;
        if (dt <= 1) return m_hold;
        if (m_mode != 2'b01) begin
            if (dt >= 2 + m_span()) return 32'd0;
            return sat(m_n, (dt - 2) / m_q());
        end
        ph  = (dt - 1) % (m_span() + 2);
        per = (dt - 1) / (m_span() + 2);
        if (ph == 0) return (per == 0) ? m_hold : 32'd0;
        if (ph > m_span()) return 32'd0;
        return sat(m_n, (ph - 1) / m_q());
    endfunction

    function automatic logic m_irq(input int t);
        int dt;
        if (!m_run) return 1'b0;
        dt = t - m_k;
        if (m_mode != 2'b01) return m_im && (dt >= 2 + m_span());
        return m_im && (dt >= 1) && (((dt - 1) % (m_span() + 2)) == m_span() + 1);
    endfunction

    function automatic logic m_en(input int t);
        if (!m_run) return 1'b0;
        if (m_mode != 2'b01) return (t - m_k) < 3 + m_span();
        return 1'b1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a, input int t);
        case (a)
            TIMER_CTRL:   return {28'd0, m_im, m_mode, m_en(t)};
            TIMER_PRESET: return m_preset;
            TIMER_COUNT:  return m_count(t);
`ifdef TIMER_PRESCALER_EN
            default:      return {16'd0, m_psc};
`else
            default:      return 32'd0;
`endif
        endcase
    endfunction

    // Called just after write edge e == cyc
    task automatic m_write(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] c;
        case (a)
            TIMER_CTRL: begin
                c      = m_count(cyc - 1);
                m_hold = c;
                m_mode = d[2:1];
                m_im   = d[3];
                m_run  = d[0];
                if (d[0]) begin
                    m_k = cyc;
                    m_n = m_preset;
                end
            end
            TIMER_PRESET: m_preset = d;
            TIMER_PSC: begin
`ifdef TIMER_PRESCALER_EN
                m_psc = d[15:0];
`endif
            end
            default: ;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            e = sbq.pop_front();
            chk("scoreboard_stale", 32'(e.cyc), 32'(cyc));
        end
        if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
            e = sbq.pop_front();
            if (addr !== e.a) begin
                chk("addr_sync", {30'd0, addr}, {30'd0, e.a});
            end else begin
                chk($sformatf("dout[a=%0d]", e.a), dout, e.d);
            end
            chk("irq", {31'd0, irq}, {31'd0, e.irq});
        end
    end

    task automatic step(input logic [1:0] a, input logic w, input logic [31:0] d);
        exp_t e;
        addr  = a;
        we    = w;
        din   = d;
        e.cyc = cyc;
        e.a   = a;
        e.d   = m_read(a, cyc);
        e.irq = m_irq(cyc);
        sbq.push_back(e);
        @(posedge clk);
        #1;
        we = 1'b0;
        if (w) m_write(a, d);
    endtask

    task automatic scenario(input logic [31:0] n, input logic [1:0] mode, input logic im,
                            input int run_cyc, input logic [31:0] stop_d);
        step(TIMER_PRESET, 1'b1, n);
        step(TIMER_CTRL, 1'b1, ($urandom() & 32'hFFFF_FFF0) | {28'd0, im, mode, 1'b1});
        for (int i = 0; i < run_cyc; i++) step(2'($urandom_range(0, 3)), 1'b0, 32'd0);
        step(TIMER_CTRL, 1'b1, stop_d);
        step(TIMER_COUNT, 1'b0, 32'd0);
        step(TIMER_CTRL, 1'b0, 32'd0);
    endtask

    initial begin
        int pulses;
        int guard;

        // Reset held with a CTRL write pending: everything reads 0
        @(posedge clk);
        #1;
        we  = 1'b1;
        din = 32'h9;
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            addr  = 2'(i);
            e.cyc = cyc; e.a = 2'(i); e.d = 32'd0; e.irq = 1'b0;
            sbq.push_back(e);
            @(posedge clk);
            #1;
        end
        we  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(2'(i), 1'b0, 32'd0);

        // One-shot PRESET=5 with IM, then CTRL=0 drops irq
        step(TIMER_PRESET, 1'b1, 32'd5);
        step(TIMER_CTRL, 1'b1, 32'h9);
        for (int i = 0; i < 10; i++) step(TIMER_COUNT, 1'b0, 32'd0);
        step(TIMER_CTRL, 1'b0, 32'd0);
        step(TIMER_CTRL, 1'b1, 32'd0);
        step(TIMER_CTRL, 1'b0, 32'd0);

        // Auto-reload PRESET=3: one pulse every 5 cycles
        step(TIMER_PRESET, 1'b1, 32'd3);
        step(TIMER_CTRL, 1'b1, 32'hB);
        step(TIMER_COUNT, 1'b0, 32'd0);
        pulses = 0;
        for (int i = 0; i < 50; i++) begin
            if (irq === 1'b1) pulses++;
            step(TIMER_COUNT, 1'b0, 32'd0);
        end
        chk("reload_pulses_50", 32'(pulses), 32'd10);
        step(TIMER_CTRL, 1'b1, 32'd0);

        // IM=0 one-shot, then CTRL=0x8 must not raise irq
        scenario(32'd2, 2'b00, 1'b0, 8, 32'h8);
        step(TIMER_COUNT, 1'b0, 32'd0);
        step(TIMER_CTRL, 1'b1, 32'd0);

        // PRESET rewritten mid-count, then stop at 40
        step(TIMER_PRESET, 1'b1, 32'd100);
        step(TIMER_CTRL, 1'b1, 32'h9);
        guard = 0;
        while (m_count(cyc) != 32'd50 && guard < 200) begin step(TIMER_COUNT, 1'b0, 32'd0); guard++; end
        chk("reach_50", m_count(cyc), 32'd50);
        step(TIMER_PRESET, 1'b1, 32'd2);
        guard = 0;
        while (m_count(cyc) != 32'd40 && guard < 200) begin step(TIMER_COUNT, 1'b0, 32'd0); guard++; end
        chk("reach_40", m_count(cyc), 32'd40);
        step(TIMER_CTRL, 1'b1, 32'd0);
        for (int i = 0; i < 3; i++) step(TIMER_COUNT, 1'b0, 32'd0);

`ifdef TIMER_PRESCALER_EN
        step(TIMER_PSC, 1'b1, 32'd3);
        scenario(32'd2, 2'b00, 1'b1, 14, 32'd0);
`endif

        // Randomized runs
        for (int s = 0; s < 16; s++) begin
            step(TIMER_PSC, 1'b1, ($urandom() & 32'hFFFF_0000) | 32'($urandom_range(0, 3)));
            scenario(32'($urandom_range(0, 12)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     $urandom_range(1, 40), $urandom() & 32'hFFFF_FFFE);
        end

        // Asynchronous reset mid-count
        step(TIMER_PSC, 1'b1, 32'd0);
        scenario(32'd0, 2'b00, 1'b1, 0, 32'd0);
        step(TIMER_PRESET, 1'b1, 32'd20);
        step(TIMER_CTRL, 1'b1, 32'hB);
        for (int i = 0; i < 6; i++) step(TIMER_COUNT, 1'b0, 32'd0);
        addr = TIMER_COUNT;
        #2;
        chk("count_before_async_rst", dout, m_count(cyc));
        rst = 1'b0;
        #1;
        chk("count_async_rst", dout, 32'd0);
        addr = TIMER_PRESET;
        #1;
        chk("preset_async_rst", dout, 32'd0);
        m_preset = 32'd0; m_n = 32'd0; m_hold = 32'd0; m_run = 1'b0;
        m_mode = 2'd0; m_im = 1'b0; m_psc = 16'd0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) step(2'(i), 1'b0, 32'd0);

        guard = 0;
        while (sbq.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
        if (sbq.size() > 0) chk("scoreboard_drain", 32'(sbq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
